// File: rtl/axil_master_ctrl.sv
// ---------------------------------------------------------------------------
// axil_master_ctrl
//
// AXI4-Lite master that turns a single-outstanding CPU request/response port
// into traffic on the five AXI-Lite channels. One transaction FSM drives all
// channels. AW and W complete independently. Misaligned requests are rejected
// without bus activity. A per-transaction cycle budget aborts the transaction
// when a slave stops responding.
//
// Ports
//   ACLK, ARESETn         clock (rising edge), asynchronous active-low reset
//   AW*/W*/B*             write address / write data / write response channels
//   AR*/R*                read address / read data channels
//   req_*                 CPU request: valid/ready, write flag, addr, wdata, wstrb
//   rsp_*                 CPU response: valid/ready, rdata, resp, timeout flag
//   busy                  high whenever the FSM is not idle
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module axil_master_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    WVALID,
   input  logic                    WREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    BVALID,
   output logic                    BREADY,
   input  logic [1:0]              BRESP,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    RVALID,
   output logic                    RREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic                    busy
);

   localparam int OFFS_BITS = $clog2(DATA_WIDTH / 8);
   // Counter only needs to reach TIMEOUT_CYCLES-1: that value marks the last
   // allowed cycle, and the abort is taken at the end of it.
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR      = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_ADDR = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;
   localparam logic [2:0] RESP    = 3'd5;

   logic [2:0]       state;
   logic [TMO_W-1:0] tmo_cnt;

   logic misaligned;
   logic active;
   logic aw_fire, w_fire, b_fire, ar_fire, r_fire, hs_fire;
   logic wr_done;
   logic tmo_hit;
   logic abort;

   assign misaligned = |req_addr[OFFS_BITS-1:0];
   assign active     = (state == WR) || (state == WR_RESP) ||
                       (state == RD_ADDR) || (state == RD_DATA);

   assign aw_fire = AWVALID && AWREADY;
   assign w_fire  = WVALID  && WREADY;
   assign b_fire  = BVALID  && BREADY;
   assign ar_fire = ARVALID && ARREADY;
   assign r_fire  = RVALID  && RREADY;
   assign hs_fire = aw_fire || w_fire || b_fire || ar_fire || r_fire;

   // A channel is finished once its VALID is low or it handshakes this cycle.
   assign wr_done = (!AWVALID || AWREADY) && (!WVALID || WREADY);

   // A handshake landing in the expiry cycle wins over the abort. The counter
   // saturates, so a later phase that stalls is aborted on its first cycle.
   assign tmo_hit = TMO_EN && (tmo_cnt >= TMO_LAST);
   assign abort   = active && tmo_hit && !hs_fire;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         tmo_cnt <= '0;
      end else if (!active) begin
         tmo_cnt <= '0;
      end else if (!tmo_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state       <= IDLE;
         AWVALID     <= 1'b0;
         AWADDR      <= '0;
         WVALID      <= 1'b0;
         WDATA       <= '0;
         WSTRB       <= '0;
         BREADY      <= 1'b0;
         ARVALID     <= 1'b0;
         ARADDR      <= '0;
         RREADY      <= 1'b0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= 2'b00;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
      end else if (abort) begin
         AWVALID     <= 1'b0;
         WVALID      <= 1'b0;
         BREADY      <= 1'b0;
         ARVALID     <= 1'b0;
         RREADY      <= 1'b0;
         rsp_valid   <= 1'b1;
         rsp_resp    <= 2'b10;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b1;
         state       <= RESP;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (req_write) begin
                     AWADDR <= req_addr;
                     WDATA  <= req_wdata;
                     WSTRB  <= req_wstrb;
                  end else begin
                     ARADDR <= req_addr;
                  end
                  if (misaligned) begin
                     rsp_valid   <= 1'b1;
                     rsp_resp    <= 2'b10;
                     rsp_rdata   <= '0;
                     rsp_timeout <= 1'b0;
                     state       <= RESP;
                  end else if (req_write) begin
                     AWVALID <= 1'b1;
                     WVALID  <= 1'b1;
                     state   <= WR;
                  end else begin
                     ARVALID <= 1'b1;
                     state   <= RD_ADDR;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WR: begin
               if (aw_fire) AWVALID <= 1'b0;
               if (w_fire)  WVALID  <= 1'b0;
               if (wr_done) begin
                  BREADY <= 1'b1;
                  state  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (b_fire) begin
                  BREADY      <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_resp    <= BRESP;
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b0;
                  state       <= RESP;
               end
            end
            RD_ADDR: begin
               if (ar_fire) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_fire) begin
                  RREADY      <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_resp    <= RRESP;
                  rsp_rdata   <= RDATA;
                  rsp_timeout <= 1'b0;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axil_master_ctrl
//
// Directed bench for axil_master_ctrl. A 32-bit instance (TIMEOUT_CYCLES=8)
// covers write, read, skewed write, misalignment, timeout, backpressure and
// reset; a 64-bit instance covers wide-bus alignment. The slave side is driven
// cycle by cycle from the single initial block. Cycle N below is the cycle
// that starts N rising edges after the request was presented.
// ---------------------------------------------------------------------------
module tb_axil_master_ctrl;

   logic        ACLK;
   logic        ARESETn;

   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   logic        x_AWVALID, x_AWREADY, x_WVALID, x_WREADY, x_BVALID, x_BREADY;
   logic        x_ARVALID, x_ARREADY, x_RVALID, x_RREADY;
   logic [31:0] x_AWADDR, x_ARADDR;
   logic [63:0] x_WDATA, x_RDATA;
   logic [7:0]  x_WSTRB;
   logic [1:0]  x_BRESP, x_RRESP;
   logic        x_req_valid, x_req_ready, x_req_write;
   logic [31:0] x_req_addr;
   logic [63:0] x_req_wdata;
   logic [7:0]  x_req_wstrb;
   logic        x_rsp_valid, x_rsp_ready, x_rsp_timeout, x_busy;
   logic [63:0] x_rsp_rdata;
   logic [1:0]  x_rsp_resp;

   int n_pass  = 0;
   int n_total = 0;

   axil_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   axil_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(256)) dut64 (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID(x_AWVALID), .AWREADY(x_AWREADY), .AWADDR(x_AWADDR),
      .WVALID(x_WVALID), .WREADY(x_WREADY), .WDATA(x_WDATA), .WSTRB(x_WSTRB),
      .BVALID(x_BVALID), .BREADY(x_BREADY), .BRESP(x_BRESP),
      .ARVALID(x_ARVALID), .ARREADY(x_ARREADY), .ARADDR(x_ARADDR),
      .RVALID(x_RVALID), .RREADY(x_RREADY), .RDATA(x_RDATA), .RRESP(x_RRESP),
      .req_valid(x_req_valid), .req_ready(x_req_ready), .req_write(x_req_write),
      .req_addr(x_req_addr), .req_wdata(x_req_wdata), .req_wstrb(x_req_wstrb),
      .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_rdata(x_rsp_rdata),
      .rsp_resp(x_rsp_resp), .rsp_timeout(x_rsp_timeout), .busy(x_busy)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      ARESETn   = 1'b0;
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      rsp_ready = 0;
      x_AWREADY = 0; x_WREADY = 0; x_BVALID = 0; x_BRESP = 0;
      x_ARREADY = 0; x_RVALID = 0; x_RDATA = 0; x_RRESP = 0;
      x_req_valid = 0; x_req_write = 0; x_req_addr = 0; x_req_wdata = 0; x_req_wstrb = 0;
      x_rsp_ready = 0;

      // ---------------- reset state ----------------
      #3;
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_arvalid", ARVALID, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      #9 ARESETn = 1'b1;
      step();
      chk("idle_req_ready", req_ready, 1);

      // ---------------- write, zero-wait slave ----------------
      req_valid = 1; req_write = 1; req_addr = 32'h10;
      req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
      step();                                          // cycle 1
      req_valid = 0;
      chk("wr_c1_awvalid", AWVALID, 1);
      chk("wr_c1_wvalid", WVALID, 1);
      chk("wr_c1_awaddr", AWADDR, 32'h10);
      chk("wr_c1_wdata", WDATA, 32'hDEADBEEF);
      chk("wr_c1_wstrb", WSTRB, 4'hF);
      chk("wr_c1_req_ready", req_ready, 0);
      chk("wr_c1_busy", busy, 1);
      AWREADY = 1; WREADY = 1;
      step();                                          // cycle 2
      chk("wr_c2_awvalid", AWVALID, 0);
      chk("wr_c2_wvalid", WVALID, 0);
      chk("wr_c2_bready", BREADY, 1);
      AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00;
      step();                                          // cycle 3
      chk("wr_c3_rsp_valid", rsp_valid, 1);
      chk("wr_c3_rsp_resp", rsp_resp, 2'b00);
      chk("wr_c3_rsp_rdata", rsp_rdata, 0);
      chk("wr_c3_bready", BREADY, 0);
      BVALID = 0; rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("wr_done_rsp_valid", rsp_valid, 0);
      chk("wr_done_req_ready", req_ready, 1);
      $display("txn write addr=0x10 done");

      // ---------------- read addr 0, 3 wait cycles, then backpressure --------
      req_valid = 1; req_write = 0; req_addr = 32'h0;
      step();                                          // cycle 1
      req_valid = 0;
      chk("rd_c1_arvalid", ARVALID, 1);
      chk("rd_c1_araddr", ARADDR, 0);
      ARREADY = 1;
      step();                                          // cycle 2
      chk("rd_c2_arvalid", ARVALID, 0);
      chk("rd_c2_rready", RREADY, 1);
      ARREADY = 0;
      step(); step(); step();                          // cycles 3..5
      chk("rd_c5_rready", RREADY, 1);
      RVALID = 1; RDATA = 32'h12345678; RRESP = 2'b00;
      step();                                          // cycle 6
      RVALID = 0; RDATA = 32'hFFFFFFFF;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("rd_rsp_resp", rsp_resp, 2'b00);
      chk("rd_rready_low", RREADY, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h12345678);
         chk("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("rd_done_rsp_valid", rsp_valid, 0);
      $display("txn read addr=0x0 done");

      // ---------------- skewed write ----------------
      req_valid = 1; req_write = 1; req_addr = 32'h20;
      req_wdata = 32'hA5A55A5A; req_wstrb = 4'h3;
      step();                                          // cycle 1
      req_valid = 0;
      WREADY = 1;
      step();                                          // cycle 2
      WREADY = 0;
      chk("sk_c2_wvalid", WVALID, 0);
      chk("sk_c2_awvalid", AWVALID, 1);
      step();                                          // cycle 3
      chk("sk_c3_awvalid", AWVALID, 1);
      chk("sk_c3_bready", BREADY, 0);
      step();                                          // cycle 4
      chk("sk_c4_awvalid", AWVALID, 1);
      chk("sk_c4_bready", BREADY, 0);
      AWREADY = 1;
      step();                                          // cycle 5
      AWREADY = 0;
      chk("sk_c5_awvalid", AWVALID, 0);
      chk("sk_c5_bready", BREADY, 1);
      BVALID = 1; BRESP = 2'b01;
      step();                                          // cycle 6
      BVALID = 0; BRESP = 2'b00;
      chk("sk_rsp_valid", rsp_valid, 1);
      chk("sk_rsp_resp", rsp_resp, 2'b01);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      $display("txn skewed write addr=0x20 done");

      // ---------------- misaligned read, 32-bit bus ----------------
      req_valid = 1; req_write = 0; req_addr = 32'h6;
      step();
      req_valid = 0;
      chk("mis_arvalid", ARVALID, 0);
      chk("mis_awvalid", AWVALID, 0);
      chk("mis_wvalid", WVALID, 0);
      chk("mis_rsp_valid", rsp_valid, 1);
      chk("mis_rsp_resp", rsp_resp, 2'b10);
      chk("mis_rsp_timeout", rsp_timeout, 0);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      $display("txn misaligned addr=0x6 done");

      // ---------------- timeout: ARREADY never asserted ----------------
      req_valid = 1; req_write = 0; req_addr = 32'h40;
      step();                                          // cycle 1
      req_valid = 0;
      for (int c = 1; c <= 8; c++) begin
         chk("to_arvalid_held", ARVALID, 1);
         chk("to_rsp_valid_low", rsp_valid, 0);
         step();
      end                                              // now cycle 9
      chk("to_arvalid_drop", ARVALID, 0);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_resp", rsp_resp, 2'b10);
      chk("to_rsp_timeout", rsp_timeout, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("to_req_ready", req_ready, 1);
      $display("txn timeout addr=0x40 done");

      // next request proceeds normally
      req_valid = 1; req_write = 0; req_addr = 32'h44;
      step();
      req_valid = 0;
      chk("post_to_arvalid", ARVALID, 1);
      ARREADY = 1;
      step();
      ARREADY = 0; RVALID = 1; RDATA = 32'hCAFEF00D; RRESP = 2'b00;
      step();
      RVALID = 0;
      chk("post_to_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("post_to_timeout", rsp_timeout, 0);
      chk("post_to_resp", rsp_resp, 2'b00);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      $display("txn read after timeout addr=0x44 done");

      // ---------------- 64-bit bus alignment ----------------
      x_req_valid = 1; x_req_write = 0; x_req_addr = 32'h8;
      step();
      x_req_valid = 0;
      chk("w64_arvalid", x_ARVALID, 1);
      chk("w64_araddr", x_ARADDR, 32'h8);
      x_ARREADY = 1;
      step();
      x_ARREADY = 0; x_RVALID = 1; x_RDATA = 64'h0123456789ABCDEF;
      step();
      x_RVALID = 0;
      chk("w64_rsp_rdata", x_rsp_rdata, 64'h0123456789ABCDEF);
      chk("w64_rsp_resp", x_rsp_resp, 2'b00);
      x_rsp_ready = 1;
      step();
      x_rsp_ready = 0;
      x_req_valid = 1; x_req_write = 0; x_req_addr = 32'h4;
      step();
      x_req_valid = 0;
      chk("w64_mis_arvalid", x_ARVALID, 0);
      chk("w64_mis_resp", x_rsp_resp, 2'b10);
      x_rsp_ready = 1;
      step();
      x_rsp_ready = 0;
      $display("txn 64-bit addr=0x8 / addr=0x4 done");

      // ---------------- reset mid-write ----------------
      req_valid = 1; req_write = 1; req_addr = 32'h30;
      req_wdata = 32'h11223344; req_wstrb = 4'hF;
      step();
      req_valid = 0;
      chk("mr_awvalid_pre", AWVALID, 1);
      #2 ARESETn = 1'b0;
      #1;
      chk("mr_awvalid", AWVALID, 0);
      chk("mr_wvalid", WVALID, 0);
      chk("mr_awaddr", AWADDR, 0);
      chk("mr_wdata", WDATA, 0);
      chk("mr_busy", busy, 0);
      chk("mr_req_ready", req_ready, 0);
      #1 ARESETn = 1'b1;
      step();
      chk("mr_idle_req_ready", req_ready, 1);
      chk("mr_idle_rsp_valid", rsp_valid, 0);
      $display("txn reset mid-write done");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
